// File: rtl/sig_checker.sv
// sig_checker: after a start and a settle window, compares NSAMP qualified
// samples of obs_data with a masked expected value. Reports pass/fail, a
// saturating mismatch count, the first bad sample, and an idle-gap timeout.
//
// Handshake: obs_valid is a one-way qualifier. There is no ready, because
// the checker accepts a sample in every SAMPLE cycle where obs_valid=1.
// start is a request that is accepted only in IDLE or DONE; it is ignored
// while busy. All outputs come from registers.
module sig_checker #(
  parameter int WIDTH   = 8,
  parameter int NSAMP   = 16,
  parameter int SETTLE  = 1,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] exp_val,
  input  logic [WIDTH-1:0] exp_mask,
  input  logic             obs_valid,
  input  logic [WIDTH-1:0] obs_data,
  output logic             busy,
  output logic             done,
  output logic             passed,
  output logic             timeout,
  output logic [7:0]       err_cnt,
  output logic [WIDTH-1:0] first_bad
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Terminal counter values, computed once so the compares stay narrow.
  localparam logic [7:0]  SETTLE_LAST  = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);
  localparam logic [7:0]  NSAMP_LAST   = 8'(NSAMP - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] exp_q, mask_q;
  logic [7:0]       settle_cnt;
  logic [7:0]       samp_cnt;
  logic [15:0]      idle_cnt;

  logic start_acc;   // a start is accepted this cycle
  logic take;        // a valid sample is consumed this cycle
  logic idle_hit;    // this idle cycle reaches TIMEOUT
  logic mism;        // the current sample differs under the mask
  logic err_zero_n;  // err_cnt will still be zero after this cycle

  // Next-state decode and the per-cycle strobes used by the datapath.
  always_comb begin
    state_n    = state;
    start_acc  = 1'b0;
    take       = 1'b0;
    idle_hit   = 1'b0;
    mism       = |((obs_data ^ exp_q) & mask_q);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_acc = 1'b1;
          state_n   = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_n = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (obs_valid) begin
          take = 1'b1;
          if (samp_cnt == NSAMP_LAST) state_n = ST_DONE;
        end else if (idle_cnt == TIMEOUT_LAST) begin
          idle_hit = 1'b1;
          state_n  = ST_DONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    err_zero_n = (err_cnt == 8'd0) && !(take && mism);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Registered status flags, derived from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_n == ST_SETTLE) || (state_n == ST_SAMPLE);
      done <= (state_n == ST_DONE);
    end
  end

  // Run datapath: capture on start, count, compare, and latch the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q      <= '0;
      mask_q     <= '0;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      idle_cnt   <= '0;
      err_cnt    <= '0;
      first_bad  <= '0;
      timeout    <= 1'b0;
      passed     <= 1'b0;
    end else if (start_acc) begin
      exp_q      <= exp_val;
      mask_q     <= exp_mask;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      idle_cnt   <= '0;
      err_cnt    <= '0;
      first_bad  <= '0;
      timeout    <= 1'b0;
      passed     <= 1'b0;
    end else if (state == ST_SETTLE) begin
      settle_cnt <= settle_cnt + 8'd1;
    end else if (state == ST_SAMPLE) begin
      if (take) begin
        samp_cnt <= samp_cnt + 8'd1;
        idle_cnt <= '0;
        if (mism) begin
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          if (err_cnt == 8'd0)  first_bad <= obs_data;
        end
      end else begin
        idle_cnt <= idle_cnt + 16'd1;
        if (idle_hit) timeout <= 1'b1;
      end
      if (state_n == ST_DONE) passed <= err_zero_n && !idle_hit;
    end
  end

endmodule

// File: tb/tb_sig_checker.sv
// Directed bench for sig_checker. Three instances cover the default
// configuration, a short timeout (TIMEOUT=4) and a long run (NSAMP=255).
// Each instance has its own start line. The data inputs and reset are shared.
module tb_sig_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_t = 1'b0, start_s = 1'b0;
  logic [7:0] exp_val = 8'h00, exp_mask = 8'h00;
  logic       obs_valid = 1'b0;
  logic [7:0] obs_data = 8'h00;

  logic       busy_a, done_a, passed_a, timeout_a;
  logic [7:0] err_a, fb_a;
  logic       busy_t, done_t, passed_t, timeout_t;
  logic [7:0] err_t, fb_t;
  logic       busy_s, done_s, passed_s, timeout_s;
  logic [7:0] err_s, fb_s;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] vec [16];
  int busy_cyc;

  sig_checker #(.WIDTH(8), .NSAMP(16), .SETTLE(1), .TIMEOUT(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .exp_val(exp_val), .exp_mask(exp_mask),
    .obs_valid(obs_valid), .obs_data(obs_data), .busy(busy_a), .done(done_a),
    .passed(passed_a), .timeout(timeout_a), .err_cnt(err_a), .first_bad(fb_a));

  sig_checker #(.WIDTH(8), .NSAMP(16), .SETTLE(1), .TIMEOUT(4)) u_to (
    .clk(clk), .rst_n(rst_n), .start(start_t), .exp_val(exp_val), .exp_mask(exp_mask),
    .obs_valid(obs_valid), .obs_data(obs_data), .busy(busy_t), .done(done_t),
    .passed(passed_t), .timeout(timeout_t), .err_cnt(err_t), .first_bad(fb_t));

  sig_checker #(.WIDTH(8), .NSAMP(255), .SETTLE(1), .TIMEOUT(64)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .exp_val(exp_val), .exp_mask(exp_mask),
    .obs_valid(obs_valid), .obs_data(obs_data), .busy(busy_s), .done(done_s),
    .passed(passed_s), .timeout(timeout_s), .err_cnt(err_s), .first_bad(fb_s));

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Advance to 1 ns after the next rising edge, then drive and sample there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full run on u_dut. Start, one settle cycle, then 16 valid samples from vec.
  // Optionally pulses start and changes exp/mask mid-run, which must be ignored.
  task automatic run_a(input logic [7:0] e, input logic [7:0] m, input bit disturb);
    exp_val = e; exp_mask = m;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    busy_cyc = 0;
    if (busy_a) busy_cyc++;
    obs_valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      if (busy_a) busy_cyc++;
      obs_valid = 1'b1;
      obs_data  = vec[i];
      if (disturb && i == 7) begin
        start_a = 1'b1; exp_val = ~e; exp_mask = 8'hFF;
      end else begin
        start_a = 1'b0;
      end
      tick();
    end
    start_a = 1'b0;
    obs_valid = 1'b0;
  endtask

  initial begin
    // Reset state.
    #2;
    check("rst_busy", busy_a, 0);   check("rst_done", done_a, 0);
    check("rst_passed", passed_a, 0); check("rst_err", err_a, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy_a, 0);

    // Clean run: 16 good samples, busy for settle + 16.
    for (int i = 0; i < 16; i++) vec[i] = 8'h01;
    run_a(8'h01, 8'hFF, 1'b0);
    check("good_done", done_a, 1);   check("good_passed", passed_a, 1);
    check("good_err", err_a, 0);     check("good_busy", busy_a, 0);
    check("good_busy_cyc", busy_cyc, 17);

    // Two bad samples (3rd and 9th). The first bad value is 8'h00.
    vec[2] = 8'h00; vec[8] = 8'h81;
    run_a(8'h01, 8'hFF, 1'b0);
    check("bad_done", done_a, 1);    check("bad_passed", passed_a, 0);
    check("bad_err", err_a, 2);      check("bad_first", fb_a, 8'h00);
    // The result holds in DONE.
    tick(); tick();
    check("hold_err", err_a, 2);     check("hold_done", done_a, 1);

    // The mask hides the upper nibble. Start and exp changes mid-run are ignored.
    for (int i = 0; i < 16; i++) vec[i] = 8'hF5;
    run_a(8'h05, 8'h0F, 1'b1);
    exp_val = 8'h00; exp_mask = 8'h00;
    check("mask_passed", passed_a, 1); check("mask_err", err_a, 0);
    check("mask_done", done_a, 1);

    // A zero mask never mismatches.
    for (int i = 0; i < 16; i++) vec[i] = 8'(i * 37 + 3);
    run_a(8'h5A, 8'h00, 1'b0);
    check("zmask_passed", passed_a, 1); check("zmask_err", err_a, 0);

    // Timeout on u_to: 2 valid samples, then 4 idle cycles.
    exp_val = 8'h01; exp_mask = 8'hFF;
    start_t = 1'b1; tick(); start_t = 1'b0;
    tick();
    obs_valid = 1'b1; obs_data = 8'h01; tick(); tick();
    obs_valid = 1'b0;
    tick(); tick(); tick();
    check("to_not_yet", done_t, 0);
    tick();
    check("to_done", done_t, 1);     check("to_flag", timeout_t, 1);
    check("to_passed", passed_t, 0); check("to_err", err_t, 0);

    // Saturation on u_sat: 300 mismatching valid cycles, with the run ending at 255.
    exp_val = 8'h01; exp_mask = 8'hFF;
    start_s = 1'b1; tick(); start_s = 1'b0;
    tick();
    obs_valid = 1'b1; obs_data = 8'hA5;
    for (int i = 0; i < 300; i++) tick();
    obs_valid = 1'b0;
    check("sat_done", done_s, 1);    check("sat_err", err_s, 255);
    check("sat_passed", passed_s, 0); check("sat_first", fb_s, 8'hA5);
    start_s = 1'b1; tick(); start_s = 1'b0;
    check("sat_restart_busy", busy_s, 1); check("sat_restart_err", err_s, 0);
    check("sat_restart_done", done_s, 0);

    // Asynchronous reset mid-SAMPLE, after a mismatch has been counted.
    exp_val = 8'h01; exp_mask = 8'hFF;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick();
    obs_valid = 1'b1; obs_data = 8'h7E;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_err", err_a, 5);
    #2 rst_n = 1'b0;
    #0.5;
    check("arst_busy", busy_a, 0);   check("arst_done", done_a, 0);
    check("arst_passed", passed_a, 0); check("arst_timeout", timeout_a, 0);
    check("arst_err", err_a, 0);     check("arst_first", fb_a, 0);
    #0.5 rst_n = 1'b1;
    obs_valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) vec[i] = 8'h01;
    run_a(8'h01, 8'hFF, 1'b0);
    check("post_rst_passed", passed_a, 1); check("post_rst_err", err_a, 0);
    check("post_rst_busy_cyc", busy_cyc, 17);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net in case the main sequence never completes.
  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
